// File: rtl/dsp_cic_pkg.sv
// Shared CIC definitions: cut-method names, bit-growth and clog2 helpers.
package dsp_cic_pkg;

  localparam string CUT_ROUND = "ROUND";
  localparam string CUT_TRUNC = "CUT";

  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned     r;
    longint unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  // Full-precision width: BIN + ceil(log2((R*M)^N)), divided by R for interpolation.
  function automatic int unsigned cic_bout(input int unsigned bin, input int unsigned r,
                                           input int unsigned m, input int unsigned n,
                                           input bit interp);
    longint unsigned g;
    g = 1;
    for (int unsigned i = 0; i < n; i++) g = g * 64'(r) * 64'(m);
    if (interp) g = g / 64'(r);
    return bin + clog2(g);
  endfunction

endpackage

// File: rtl/dsp_cic_int_if.sv
// Sample-slot and output bundle of the CIC interpolator.
interface dsp_cic_int_if #(
  parameter int unsigned BIN  = 16,
  parameter int unsigned BOUT = 34,
  parameter int unsigned COUT = 16
);
  logic [BIN-1:0]  din;
  logic            din_vld;
  logic            din_rdy;
  logic [BOUT-1:0] dout;
  logic [COUT-1:0] dout_cut;
  logic            dvld;
  logic            uflow;

  modport master (output din, din_vld, input din_rdy, dout, dout_cut, dvld, uflow);
  modport slave  (input din, din_vld, output din_rdy, dout, dout_cut, dvld, uflow);
endinterface

// File: rtl/dsp_cic_round_cut.sv
// Narrows a full-precision CIC word to COUT bits by rounding (half away
// from zero) or truncation. Optional macro DSP_CIC_INT_SAT_EN clamps the
// positive overflow produced by rounding instead of wrapping.
module dsp_cic_round_cut
  import dsp_cic_pkg::*;
#(
  parameter int unsigned BOUT       = 34,
  parameter int unsigned COUT       = 16,
  parameter string       CUT_METHOD = CUT_ROUND
) (
  input  logic [BOUT-1:0] din,
  output logic [COUT-1:0] dout
);
  localparam int unsigned SH = BOUT - COUT;

  logic [COUT-1:0] top;
  assign top = din[BOUT-1:SH];

  if (CUT_METHOD == CUT_TRUNC) begin : g_cut
    logic unused_low;
    assign unused_low = ^din[SH-1:0];
    assign dout = top;
  end else begin : g_round
    logic [BOUT-1:0] below_mask;
    logic            guard;
    logic            sticky;
    logic            carry;
    // top is the floor; negatives need more than an exact half to move up
    assign below_mask = ~({BOUT{1'b1}} << (SH - 1));
    assign guard      = din[SH-1];
    assign sticky     = |(din & below_mask);
    assign carry      = guard & (~din[BOUT-1] | sticky);
`ifdef DSP_CIC_INT_SAT_EN
    logic [COUT:0] wide;
    assign wide = {top[COUT-1], top} + (COUT + 1)'(carry);
    assign dout = (wide[COUT] != wide[COUT-1]) ? {1'b0, {(COUT - 1){1'b1}}} : wide[COUT-1:0];
`else
    assign dout = top + COUT'(carry);
`endif
  end

endmodule

// File: rtl/dsp_cic_int.sv
// CIC interpolator: N comb stages at the slot rate, zero-stuff by R, N
// integrators at the clock rate, registered full-precision and narrowed
// outputs. Optional macro DSP_CIC_INT_SAT_EN (in dsp_cic_round_cut)
// saturates rounding overflow on dout_cut.
module dsp_cic_int
  import dsp_cic_pkg::*;
#(
  parameter int unsigned R          = 20,
  parameter int unsigned M          = 1,
  parameter int unsigned N          = 5,
  parameter int unsigned BIN        = 16,
  parameter int unsigned COUT       = 16,
  parameter string       CUT_METHOD = CUT_ROUND,
  parameter int unsigned BOUT       = cic_bout(BIN, R, M, N, 1'b1)
) (
  input logic          clk,
  input logic          rst_n,
  dsp_cic_int_if.slave bus
);
  localparam int unsigned CW = clog2(R);

  logic [CW-1:0]   cnt;
  logic            slot;
  logic            uflow_q;
  logic [BOUT-1:0] din_ext;
  logic [BOUT-1:0] comb_in [N];
  logic [BOUT-1:0] comb_out;
  logic [BOUT-1:0] dly [N][M];
  logic [BOUT-1:0] up;
  logic [BOUT-1:0] integ [N];
  logic [BOUT-1:0] dout_q;
  logic [N:0]      vld_sr;
  logic            dvld_q;

  // rate counter, registered accept slot and missed-slot pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      slot    <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      cnt     <= (cnt == CW'(R - 1)) ? '0 : cnt + CW'(1);
      slot    <= (cnt == CW'(R - 1));
      uflow_q <= slot & ~bus.din_vld;
    end
  end

  // comb chain evaluated on the current sample; a missed slot feeds zero
  always_comb begin
    din_ext  = bus.din_vld ? BOUT'($signed(bus.din)) : '0;
    comb_out = din_ext;
    for (int unsigned j = 0; j < N; j++) begin
      comb_in[j] = comb_out;
      comb_out   = comb_out - dly[j][M-1];
    end
  end

  // comb delay lines advance on slot edges; zero-stuffer loads otherwise 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < N; j++)
        for (int unsigned i = 0; i < M; i++) dly[j][i] <= '0;
      up <= '0;
    end else begin
      if (slot) begin
        for (int unsigned j = 0; j < N; j++) begin
          dly[j][0] <= comb_in[j];
          for (int unsigned i = 1; i < M; i++) dly[j][i] <= dly[j][i-1];
        end
      end
      up <= slot ? comb_out : '0;
    end
  end

  // pipelined integrators, each fed by the registered previous stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) integ[k] <= '0;
      dout_q <= '0;
    end else begin
      integ[0] <= integ[0] + up;
      for (int unsigned k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
      dout_q <= integ[N-1];
    end
  end

  // output valid follows the first slot through the same depth as the data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_sr <= '0;
      dvld_q <= 1'b0;
    end else begin
      vld_sr <= {vld_sr[N-1:0], vld_sr[0] | slot};
      dvld_q <= vld_sr[N];
    end
  end

  dsp_cic_round_cut #(
    .BOUT      (BOUT),
    .COUT      (COUT),
    .CUT_METHOD(CUT_METHOD)
  ) u_cut (
    .din (dout_q),
    .dout(bus.dout_cut)
  );

  assign bus.din_rdy = slot;
  assign bus.dout    = dout_q;
  assign bus.dvld    = dvld_q;
  assign bus.uflow   = uflow_q;

endmodule
